// File: rtl/hs32_mem_arbiter.sv
// Purpose  : shares one external memory bus between the instruction fetch port and the data port.
// Latency  : grant -> mem_stb next cycle; mem_ack -> ack_x/dtr_x next cycle; rejected strobe -> stl_x next cycle.
// Backpress: nothing is queued; a strobe that cannot be granted gets a one-cycle stl pulse.
//
// Ports:
//   clk, reset                  clock (rising edge) and synchronous active-low reset
//   addr_i, stb_i               instruction fetch request (stb is a one-cycle pulse)
//   ack_i, stl_i, dtr_i         instruction read data valid / request rejected / read data
//   flush                       fetch flush: pending instruction ack is discarded, same-cycle stb_i ignored
//   addr_d, dtw_d, rw_d, stb_d  data request (rw_d: 1 = write)
//   ack_d, stl_d, dtr_d         data transaction complete / request rejected / read data
//   mem_addr, mem_dtw, mem_rw   memory request fields, held from grant until mem_ack
//   mem_stb                     one-cycle memory request pulse
//   mem_ack, mem_dtr            memory response
//   err                         sticky timeout flag (only with HS32_MEM_TIMEOUT_EN)
//
// Optional build macro HS32_MEM_TIMEOUT_EN: adds a watchdog that aborts a transaction after
// TIMEOUT_CYCLES waiting cycles, stalls the owner and sets err. Without it BUSY waits forever.
module hs32_mem_arbiter #(
   parameter int DATA_PRIORITY  = 1,   // 1: data port wins ties; 0: ties alternate
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr_i,
   input  logic        stb_i,
   output logic        ack_i,
   output logic        stl_i,
   output logic [31:0] dtr_i,
   input  logic        flush,
   input  logic [31:0] addr_d,
   input  logic [31:0] dtw_d,
   input  logic        rw_d,
   input  logic        stb_d,
   output logic        ack_d,
   output logic        stl_d,
   output logic [31:0] dtr_d,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_dtw,
   output logic        mem_rw,
   output logic        mem_stb,
   input  logic        mem_ack,
`ifdef HS32_MEM_TIMEOUT_EN
   input  logic [31:0] mem_dtr,
   output logic        err
`else
   input  logic [31:0] mem_dtr
`endif
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("hs32_mem_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t      state_q, state_nx;
   logic        rr_q, rr_nx;        // 1: data port takes the next tie
   logic        drop_q, drop_nx;    // flush seen during the current fetch
   logic        ack_i_nx, stl_i_nx, ack_d_nx, stl_d_nx, mem_stb_nx, mem_rw_nx;
   logic [31:0] dtr_i_nx, dtr_d_nx, mem_addr_nx, mem_dtw_nx;
   logic        req_i;
   logic        data_first;
   logic        timeout_hit;

   // A flushing fetch stage does not really want the address it is strobing.
   assign req_i      = stb_i & ~flush;
   assign data_first = (DATA_PRIORITY != 0) | rr_q;

`ifdef HS32_MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_nx;
   logic             err_nx;

   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_nx    = state_q;
      rr_nx       = rr_q;
      drop_nx     = drop_q;
      ack_i_nx    = 1'b0;
      stl_i_nx    = 1'b0;
      ack_d_nx    = 1'b0;
      stl_d_nx    = 1'b0;
      mem_stb_nx  = 1'b0;
      dtr_i_nx    = dtr_i;
      dtr_d_nx    = dtr_d;
      mem_addr_nx = mem_addr;
      mem_dtw_nx  = mem_dtw;
      mem_rw_nx   = mem_rw;
`ifdef HS32_MEM_TIMEOUT_EN
      cnt_nx      = cnt_q;
      err_nx      = err;
`endif
      case (state_q)
         IDLE: begin
            if (req_i && stb_d) begin
               rr_nx = ~rr_q;
            end
            if (stb_d && (!req_i || data_first)) begin
               state_nx    = BUSY_D;
               mem_addr_nx = addr_d;
               mem_dtw_nx  = dtw_d;
               mem_rw_nx   = rw_d;
               mem_stb_nx  = 1'b1;
               drop_nx     = 1'b0;
               stl_i_nx    = req_i;
`ifdef HS32_MEM_TIMEOUT_EN
               cnt_nx      = '0;
`endif
            end else if (req_i) begin
               state_nx    = BUSY_I;
               mem_addr_nx = addr_i;
               mem_dtw_nx  = 32'h0;     // fetches are always reads
               mem_rw_nx   = 1'b0;
               mem_stb_nx  = 1'b1;
               drop_nx     = 1'b0;
               stl_d_nx    = stb_d;
`ifdef HS32_MEM_TIMEOUT_EN
               cnt_nx      = '0;
`endif
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ack) begin
               state_nx = IDLE;
               if (state_q == BUSY_I) begin
                  // A discarded fetch returns nothing; otherwise the ack pulse takes
                  // precedence over stalling a same-cycle re-strobe from the owner.
                  if (!drop_q && !flush) begin
                     ack_i_nx = 1'b1;
                     dtr_i_nx = mem_dtr;
                  end else begin
                     stl_i_nx = req_i;
                  end
                  stl_d_nx = stb_d;
               end else begin
                  ack_d_nx = 1'b1;
                  dtr_d_nx = mem_dtr;
                  stl_i_nx = req_i;
               end
            end else if (timeout_hit) begin
               state_nx = IDLE;
               stl_i_nx = req_i | (state_q == BUSY_I);
               stl_d_nx = stb_d | (state_q == BUSY_D);
`ifdef HS32_MEM_TIMEOUT_EN
               err_nx   = 1'b1;
`endif
            end else begin
               stl_i_nx = req_i;
               stl_d_nx = stb_d;
               if (state_q == BUSY_I && flush) begin
                  drop_nx = 1'b1;
               end
`ifdef HS32_MEM_TIMEOUT_EN
               cnt_nx = cnt_q + CNT_W'(1);
`endif
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         rr_q     <= 1'b1;
         drop_q   <= 1'b0;
         ack_i    <= 1'b0;
         stl_i    <= 1'b0;
         ack_d    <= 1'b0;
         stl_d    <= 1'b0;
         mem_stb  <= 1'b0;
         dtr_i    <= 32'h0;
         dtr_d    <= 32'h0;
         mem_addr <= 32'h0;
         mem_dtw  <= 32'h0;
         mem_rw   <= 1'b0;
`ifdef HS32_MEM_TIMEOUT_EN
         cnt_q    <= '0;
         err      <= 1'b0;
`endif
      end else begin
         state_q  <= state_nx;
         rr_q     <= rr_nx;
         drop_q   <= drop_nx;
         ack_i    <= ack_i_nx;
         stl_i    <= stl_i_nx;
         ack_d    <= ack_d_nx;
         stl_d    <= stl_d_nx;
         mem_stb  <= mem_stb_nx;
         dtr_i    <= dtr_i_nx;
         dtr_d    <= dtr_d_nx;
         mem_addr <= mem_addr_nx;
         mem_dtw  <= mem_dtw_nx;
         mem_rw   <= mem_rw_nx;
`ifdef HS32_MEM_TIMEOUT_EN
         cnt_q    <= cnt_nx;
         err      <= err_nx;
`endif
      end
   end

endmodule

// File: doc/hs32_mem_arbiter.md
Name: hs32_mem_arbiter

Overview:
- Sits directly upstream of the instruction fetch stage.
- Arbitrates one external memory bus between two requesters:
  - the instruction port (fetch);
  - the data port (execute load/store).
- Presents each requester with the pulse-strobe / ack / stall contract the fetch stage expects.
- Latches the winning request, drives one memory transaction at a time, and returns read data with a registered ack, or a one-cycle stall if the request could not be accepted.

Parameters:
- DATA_PRIORITY, 1: 1 = data port wins simultaneous requests; 0 = round-robin, the winner alternates on each tie.
- TIMEOUT_CYCLES, 64: cycles without mem_ack before a transaction is aborted. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- addr_i  in  32  instruction fetch address.
- stb_i  in  1  instruction request strobe; one-cycle pulse.
- ack_i  out  1  instruction data valid; one-cycle pulse.
- stl_i  out  1  instruction request rejected; one-cycle pulse.
- dtr_i  out  32  instruction read data.
- flush  in  1  fetch is flushing; the pending instruction ack is discarded.
- addr_d  in  32  data address.
- dtw_d  in  32  data write value.
- rw_d  in  1  1 = write, 0 = read.
- stb_d  in  1  data request strobe; one-cycle pulse.
- ack_d  out  1  data transaction complete; one-cycle pulse.
- stl_d  out  1  data request rejected; one-cycle pulse.
- dtr_d  out  32  data read value.
- mem_addr  out  32  memory address.
- mem_dtw  out  32  memory write data.
- mem_rw  out  1  memory direction.
- mem_stb  out  1  memory request; one-cycle pulse.
- mem_ack  in  1  memory response valid.
- mem_dtr  in  32  memory read data.
- err  out  1  sticky timeout flag; present only with MEM_TIMEOUT_EN.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state = IDLE;
  - all ack/stl/mem_stb/err = 0;
  - dtr_i, dtr_d, mem_addr, mem_dtw = 0; mem_rw = 0;
  - round-robin pointer selects the data port.
  - Reset mid-transaction abandons it; a late mem_ack is ignored.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE, stb in cycle t:
  - winner's addr/dtw/rw latched into mem_addr/mem_dtw/mem_rw;
  - mem_stb = 1 in cycle t+1 only;
  - state = BUSY_I or BUSY_D.
- Tie (stb_i and stb_d both in cycle t):
  - the winner is chosen per DATA_PRIORITY;
  - the loser sees stl = 1 in t+1.
  - Round-robin pointer flips after each tie.
- BUSY_x, mem_ack in cycle u:
  - dtr_x <= mem_dtr and ack_x = 1 in u+1;
  - state = IDLE in u+1.
  - A new stb is accepted in u+1; minimum spacing between grants is 3 cycles.
- Any stb arriving while in BUSY_x (either port) gets stl = 1 next cycle. It is not queued.
- mem_addr/mem_dtw/mem_rw hold stable from grant until mem_ack.
- Write transactions: ack_d pulses; dtr_d is updated with mem_dtr, and its value is don't-care.
- flush (level) while in BUSY_I, or in the cycle mem_ack arrives:
  - the memory transaction completes normally;
  - ack_i is suppressed and dtr_i is not updated.
  - flush never affects the data port.
- flush with stb_i in the same cycle: the stb_i is ignored; no grant and no stall.
- mem_ack while IDLE is ignored.
- ack_x and stl_x are never high in the same cycle.

Optional Feature:
- Macro: HS32_MEM_TIMEOUT_EN.
- With the macro defined:
  - a counter clears on grant and increments each BUSY cycle without mem_ack;
  - when the count reaches TIMEOUT_CYCLES, the owner gets stl = 1 next cycle, err is set (sticky until reset), and state = IDLE;
  - a late mem_ack is then ignored.
- Without the macro: no counter, no err port; BUSY waits indefinitely.

Test Plan:
- stb_i, addr_i=0x100 in cycle 0; memory acks in cycle 3 with 0xDEADBEEF -> mem_stb=1 at cycle 1 only, mem_addr=0x100 held through cycle 3, ack_i=1 with dtr_i=0xDEADBEEF at cycle 4.
- stb_i and stb_d together, DATA_PRIORITY=1 -> stl_i=1 next cycle; mem_addr=addr_d; ack_d after mem_ack. With DATA_PRIORITY=0 and three ties -> winners d, i, d.
- Write: stb_d, rw_d=1, addr_d=0x2000, dtw_d=0x12345678 -> mem_rw=1, mem_dtw=0x12345678 held until mem_ack; ack_d pulses once.
- stb_d during BUSY_I -> stl_d=1 one cycle; the instruction transaction still completes with ack_i.
- flush asserted during BUSY_I, mem_ack 2 cycles later -> no ack_i, dtr_i unchanged, state IDLE, a new stb_i is accepted the following cycle.
- HS32_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ack never asserted -> stl_i at 5th BUSY cycle+1, err=1 until reset; reset=0 for one edge -> err=0, state IDLE.
